// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
// Sequences one CNN inference per host start: streams a WIDTH x HEIGHT
// frame out of a synchronous pixel buffer in raster order, waits for the
// CNN decision, latches it and signals completion with a one-cycle done.
// Abort routes through a FLUSH state that pulses cnn_flush.
// Optional build macro CNN_SEQ_TIMEOUT_EN adds a WAIT watchdog that forces
// result 4'hF / result_err after TIMEOUT_CYCLES without a CNN answer.
module cnn_frame_sequencer #(
    parameter int WIDTH          = 28,
    parameter int HEIGHT         = 28,
    parameter int DATA_BITS      = 32,
    parameter int ADDR_BITS      = 10,
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           result,
    output logic                 result_err,
    output logic                 spurious,
    output logic [15:0]          frame_cnt,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 cnn_in_val,
    output logic [DATA_BITS-1:0] cnn_data_in,
    input  logic                 cnn_out_val,
    input  logic [3:0]           cnn_decision,
    output logic                 cnn_flush
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STREAM = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 in_val_q, in_val_d;
    logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [3:0]           result_q, result_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 done_q, done_d;
    logic                 spurious_q, spurious_d;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TC_W-1:0] TO_LAST = TC_W'(TIMEOUT_CYCLES - 1);

    logic [TC_W-1:0] to_cnt_q, to_cnt_d;
    // Set when FLUSH was entered by the watchdog, so FLUSH exits to DONE.
    logic            to_done_q, to_done_d;
    logic            err_q, err_d;
`else
    // Watchdog is not built; the parameter only keeps the interface uniform.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // A read is issued every unpaused STREAM cycle; pause only matters here.
    assign rd_en       = (state_q == S_STREAM) && !pause;
    assign rd_addr     = rd_addr_q;
    assign cnn_in_val  = in_val_q;
    assign cnn_data_in = rd_data;
    assign cnn_flush   = (state_q == S_FLUSH);
    assign busy        = (state_q == S_STREAM) || (state_q == S_WAIT) ||
                         (state_q == S_FLUSH);
    assign done        = done_q;
    assign result      = result_q;
    assign frame_cnt   = frame_cnt_q;
    assign spurious    = spurious_q;
`ifdef CNN_SEQ_TIMEOUT_EN
    assign result_err  = err_q;
`else
    assign result_err  = 1'b0;
`endif

    // Next-state logic: abort outranks everything except reset in STREAM/WAIT.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        flush_cnt_d = flush_cnt_q;
        result_d    = result_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        // The beat for the read issued in an abort cycle is suppressed.
        in_val_d    = rd_en && !abort;
        spurious_d  = spurious_q | (cnn_out_val && (state_q != S_WAIT));
`ifdef CNN_SEQ_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        to_done_d   = to_done_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_STREAM;
                    rd_addr_d = '0;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else if (rd_en) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = S_WAIT;
`ifdef CNN_SEQ_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else if (cnn_out_val) begin
                    result_d    = cnn_decision;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
`ifdef CNN_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    result_d    = 4'hF;
                    err_d       = 1'b1;
                    to_done_d   = 1'b1;
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    to_cnt_d    = to_cnt_q + 1'b1;
`endif
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
`ifdef CNN_SEQ_TIMEOUT_EN
                    if (to_done_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        to_done_d = 1'b0;
                    end
`endif
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset returns every output to idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            in_val_q    <= 1'b0;
            flush_cnt_q <= '0;
            result_q    <= 4'h0;
            frame_cnt_q <= 16'd0;
            done_q      <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            in_val_q    <= in_val_d;
            flush_cnt_q <= flush_cnt_d;
            result_q    <= result_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            spurious_q  <= spurious_d;
        end
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    // Watchdog counter, timeout-to-DONE marker and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            to_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_done_q <= to_done_d;
            err_q     <= err_d;
        end
    end
`endif

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
Controller that sequences one inference of the CNN datapath per host request.
- Reads a WIDTH x HEIGHT pixel frame from a synchronous pixel buffer and streams it in raster order onto the CNN in_val/data_in inputs.
- Waits for the CNN out_val and latches the 4-bit decision.
- Reports completion to the host through a start/busy/done handshake.
- Provides abort, a flush pulse to clear the datapath, and a frame counter.

Parameters:
WIDTH, 28, frame width in pixels
HEIGHT, 28, frame height in pixels
DATA_BITS, 32, pixel word width
ADDR_BITS, 10, pixel buffer address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT
FLUSH_CYCLES, 2, length of the cnn_flush pulse
TIMEOUT_CYCLES, 4096, WAIT watchdog limit (optional feature only)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  host request; accepted only in IDLE or DONE
abort  in  1  host abort; highest priority after rst
pause  in  1  stall streaming while high
busy  out  1  high in STREAM, WAIT, FLUSH
done  out  1  one-cycle pulse on entry to DONE
result  out  4  latched CNN decision
result_err  out  1  last frame ended by timeout
spurious  out  1  sticky: cnn_out_val seen outside WAIT
frame_cnt  out  16  completed frames, wraps at 65535 -> 0
rd_en  out  1  pixel buffer read strobe
rd_addr  out  ADDR_BITS  pixel buffer address
rd_data  in  DATA_BITS  pixel buffer data, valid 1 cycle after rd_en
cnn_in_val  out  1  to CNN in_val
cnn_data_in  out  DATA_BITS  to CNN data_in; equals rd_data
cnn_out_val  in  1  from CNN out_val
cnn_decision  in  4  from CNN decision
cnn_flush  out  1  drives CNN reset (invert at the CNN's active-low rst_n)

Behaviour:
- Reset values: state IDLE; busy, done, rd_en, cnn_in_val, cnn_flush, result_err, spurious = 0; result = 0; frame_cnt = 0; rd_addr = 0.
- States: IDLE, STREAM, WAIT, DONE, FLUSH.
- IDLE/DONE -> STREAM when start = 1.
  - rd_addr is cleared to 0.
  - The DONE result stays valid until the next start is accepted.
- STREAM:
  - Each cycle with pause = 0: rd_en = 1 at rd_addr, then rd_addr increments.
  - With pause = 1: rd_en = 0 and rd_addr holds.
  - cnn_in_val is rd_en registered one cycle. cnn_data_in = rd_data combinationally.
  - After the read of address WIDTH*HEIGHT-1 is issued, go to WAIT. Exactly WIDTH*HEIGHT in_val beats are produced per frame.
- Latency: start sampled at cycle 0; first rd_en at cycle 1; first cnn_in_val at cycle 2. With no pause, the last cnn_in_val is at cycle WIDTH*HEIGHT+1.
- WAIT:
  - On cnn_out_val = 1: result <= cnn_decision, result_err <= 0, frame_cnt increments, go to DONE.
  - A final in_val beat coincident with entry to WAIT is still delivered.
- DONE: done = 1 for exactly the entry cycle; busy = 0.
- abort = 1 in STREAM or WAIT:
  - rd_en and cnn_in_val drop the next cycle.
  - Go to FLUSH. result and frame_cnt are unchanged; no done pulse.
  - abort in IDLE/DONE is ignored.
- FLUSH:
  - cnn_flush = 1 for FLUSH_CYCLES cycles, then IDLE.
  - start is ignored in FLUSH.
- start while busy is ignored.
- start and abort in the same cycle in IDLE: start is taken.
- cnn_out_val outside WAIT sets spurious. Only rst clears spurious.
- pause has no effect outside STREAM.
- rst asserted mid-frame: immediate return to reset values. The CNN is not flushed by this block; the CNN rst_n must also be driven from system reset.

Optional Feature:
Macro CNN_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and counts cycles in WAIT.
  - If it reaches TIMEOUT_CYCLES with no cnn_out_val: result <= 4'hF, result_err <= 1, frame_cnt unchanged.
  - Then pass through FLUSH (cnn_flush pulse), then enter DONE with the done pulse.
  - cnn_out_val in the same cycle as the timeout wins: normal completion.
- Undefined: WAIT waits indefinitely; result_err is tied 0; no counter logic.

Test Plan:
- Reset, buffer preloaded with addr+1; start pulse, CNN model returns decision 7 at 200 cycles after last in_val -> 784 in_val beats with data 1..784 in order, result = 7, one done pulse, frame_cnt = 1.
- pause high for 10 cycles at pixel 100 -> no in_val beats during the stall; data continues 101.. with no skip or duplicate; total 784 beats.
- abort at pixel 300 -> rd_en/cnn_in_val low the next cycle; cnn_flush high 2 cycles; IDLE; no done; result and frame_cnt unchanged. A subsequent start completes normally.
- start held high during a frame plus an out_val injected in IDLE -> second start ignored until DONE; spurious = 1 and stays 1 after the next frame.
- Two back-to-back frames, start asserted in the DONE cycle, decisions 3 then 9 -> result 3 then 9, frame_cnt = 2, first in_val of frame 2 two cycles after start.
- With CNN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 64, CNN never answers -> after 64 WAIT cycles: cnn_flush pulse, done, result = 4'hF, result_err = 1, frame_cnt unchanged.
